// File: rtl/multdiv_controller.sv
// multdiv_controller: sequences the shared multi-cycle mult/div unit for the execute stage.
// Latency: request cycle + >=1 WAIT cycle + 1 DONE cycle (3 cycles minimum); WAIT is bounded by TIMEOUT.
// Backpressure: stall freezes PC, F/D and D/X while an op is being issued or is in flight.
//
// Ports:
//   clock, reset                 master clock, synchronous active-low reset
//   req_mult, req_div            level requests from the D/X instruction (mult wins if both)
//   flush                        execute redirect; masks a new request, kills an in-flight op
//   op_a, op_b, req_rd           operands and destination register of the requesting instruction
//   unit_ready, unit_exception,
//   unit_result                  completion handshake from the mult/div unit
//   ctrl_mult, ctrl_div          one-cycle start pulse to the unit (first WAIT cycle)
//   unit_a, unit_b               latched operands, stable from issue until the next issue
//   stall, busy                  pipeline freeze / controller not idle
//   result_valid, result,
//   result_rd                    one-cycle result beat; result and result_rd hold until next beat
//   exc_valid, exc_code          exception qualifier (pulse) and $rstatus code (4/5/6, held)
module multdiv_controller #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_mult,
  input  logic        req_div,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  req_rd,
  input  logic        unit_ready,
  input  logic        unit_exception,
  input  logic [31:0] unit_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        exc_valid,
  output logic [2:0]  exc_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] EXC_MULT    = 3'd4;
  localparam logic [2:0] EXC_DIV     = 3'd5;
  localparam logic [2:0] EXC_TIMEOUT = 3'd6;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_is_mult;
  logic [4:0]       rd_q;
  logic             req;
  logic             issue;
  logic             fin_ready;
  logic             fin_timeout;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // WAIT priority: flush kills the op, then a unit completion, then the timeout.
  // A completion landing on the timeout cycle therefore reports the real result.
  always_comb begin
    state_nxt   = state;
    req         = (req_mult | req_div) & ~flush;
    issue       = 1'b0;
    fin_ready   = 1'b0;
    fin_timeout = 1'b0;
    stall       = 1'b0;
    case (state)
      S_IDLE: begin
        stall = req;
        if (req) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (unit_ready) begin
          fin_ready = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          fin_timeout = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      // The completing instruction is still in D/X here, so its request level is ignored.
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Keep every output quiet while reset is asserted, even with a request pending.
    if (!reset) stall = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt        <= '0;
      op_is_mult <= 1'b0;
      rd_q       <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      ctrl_mult  <= 1'b0;
      ctrl_div   <= 1'b0;
      result     <= '0;
      result_rd  <= '0;
      exc_code   <= '0;
    end else begin
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      if (issue) begin
        unit_a     <= op_a;
        unit_b     <= op_b;
        rd_q       <= req_rd;
        op_is_mult <= req_mult;
        ctrl_mult  <= req_mult;
        ctrl_div   <= ~req_mult;
        cnt        <= '0;
      end else if (state == S_WAIT && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fin_ready) begin
        result    <= unit_exception ? 32'd0 : unit_result;
        exc_code  <= unit_exception ? (op_is_mult ? EXC_MULT : EXC_DIV) : 3'd0;
        result_rd <= rd_q;
      end else if (fin_timeout) begin
        result    <= 32'd0;
        exc_code  <= EXC_TIMEOUT;
        result_rd <= rd_q;
      end
    end
  end

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign exc_valid    = (state == S_DONE) && (exc_code != 3'd0);

endmodule

// File: tb/tb_multdiv_controller.sv
module tb_multdiv_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_mult, req_div, flush;
  logic [31:0] op_a, op_b;
  logic [4:0]  req_rd;
  logic        unit_ready, unit_exception;
  logic [31:0] unit_result;
  logic        ctrl_mult, ctrl_div;
  logic [31:0] unit_a, unit_b;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        exc_valid;
  logic [2:0]  exc_code;

  int checks = 0;
  int failures = 0;

  // per-op observations gathered by drive_op
  int          o_nstall, o_last_stall, o_ncm, o_cm_cyc, o_ncd, o_cd_cyc, o_nrv, o_rv_cyc, o_nev;
  logic [31:0] o_res, o_ua, o_ub, o_ua_done, o_ub_done;
  logic [4:0]  o_rd;
  logic [2:0]  o_exc;

  multdiv_controller #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .req_mult(req_mult), .req_div(req_div), .flush(flush),
    .op_a(op_a), .op_b(op_b), .req_rd(req_rd),
    .unit_ready(unit_ready), .unit_exception(unit_exception), .unit_result(unit_result),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .unit_a(unit_a), .unit_b(unit_b),
    .stall(stall), .busy(busy),
    .result_valid(result_valid), .result(result), .result_rd(result_rd),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_mult = 1'b0; req_div = 1'b0; flush = 1'b0;
    op_a = 32'h0; op_b = 32'h0; req_rd = 5'd0;
    unit_ready = 1'b0; unit_exception = 1'b0; unit_result = 32'h0;
  endtask

  // Cycle k=0 is the request cycle. Requests/operands are held for req_len cycles,
  // unit_ready pulses in cycle ready_at, flush pulses in cycle flush_at (-1 = never).
  task automatic drive_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int req_len, input int ready_at,
                          input logic exc, input logic [31:0] res, input int flush_at,
                          input int ncyc);
    o_nstall = 0; o_last_stall = -1; o_ncm = 0; o_cm_cyc = -1; o_ncd = 0; o_cd_cyc = -1;
    o_nrv = 0; o_rv_cyc = -1; o_nev = 0;
    o_res = 32'hx; o_rd = 5'hx; o_exc = 3'hx; o_ua = 32'hx; o_ub = 32'hx;
    o_ua_done = 32'hx; o_ub_done = 32'hx;
    for (int k = 0; k < ncyc; k++) begin
      req_mult       = m && (k < req_len);
      req_div        = d && (k < req_len);
      op_a           = (k < req_len) ? a : 32'hFFFF_FFFF;
      op_b           = (k < req_len) ? b : 32'hFFFF_FFFF;
      req_rd         = (k < req_len) ? rd : 5'h1F;
      unit_ready     = (k == ready_at);
      unit_exception = (k == ready_at) && exc;
      unit_result    = (k == ready_at) ? res : 32'h5A5A_5A5A;
      flush          = (k == flush_at);
      #1;
      if (stall)     begin o_nstall++; o_last_stall = k; end
      if (ctrl_mult) begin o_ncm++; o_cm_cyc = k; o_ua = unit_a; o_ub = unit_b; end
      if (ctrl_div)  begin o_ncd++; o_cd_cyc = k; o_ua = unit_a; o_ub = unit_b; end
      if (result_valid) begin
        o_nrv++; o_rv_cyc = k; o_res = result; o_rd = result_rd; o_exc = exc_code;
        o_ua_done = unit_a; o_ub_done = unit_b;
      end
      if (exc_valid) o_nev++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [109:0] v;
    v = {ctrl_mult, ctrl_div, unit_a, unit_b, stall, busy, result_valid, result, result_rd,
         exc_valid, exc_code};
    checks++;
    if (v !== 110'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", v);
    end
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_release_idle: busy=%b stall=%b expected 0 0", busy, stall);
    end
  endtask

  task automatic test_mult();
    drive_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd5, 6, 4, 1'b0, 32'd42, -1, 8);
    checks++; if (o_ncm !== 1 || o_cm_cyc !== 1) begin
      failures++; $display("FAIL mult_ctrl_pulse: count=%0d cycle=%0d expected 1 1", o_ncm, o_cm_cyc); end
    checks++; if (o_ncd !== 0) begin
      failures++; $display("FAIL mult_no_div_pulse: count=%0d expected 0", o_ncd); end
    checks++; if (o_ua !== 32'd7 || o_ub !== 32'd6) begin
      failures++; $display("FAIL mult_operands: a=%0d b=%0d expected 7 6", o_ua, o_ub); end
    checks++; if (o_nstall !== 5 || o_last_stall !== 4) begin
      failures++; $display("FAIL mult_stall: cycles=%0d last=%0d expected 5 4", o_nstall, o_last_stall); end
    checks++; if (o_nrv !== 1 || o_rv_cyc !== 5) begin
      failures++; $display("FAIL mult_result_beat: count=%0d cycle=%0d expected 1 5", o_nrv, o_rv_cyc); end
    checks++; if (o_res !== 32'd42 || o_rd !== 5'd5) begin
      failures++; $display("FAIL mult_result: result=%0d rd=%0d expected 42 5", o_res, o_rd); end
    checks++; if (o_nev !== 0 || o_exc !== 3'd0) begin
      failures++; $display("FAIL mult_no_exc: exc_valid_count=%0d code=%0d expected 0 0", o_nev, o_exc); end
    checks++; if (o_ua_done !== 32'd7 || o_ub_done !== 32'd6) begin
      failures++; $display("FAIL mult_operands_stable: a=%0d b=%0d expected 7 6", o_ua_done, o_ub_done); end
    checks++; if (result !== 32'd42 || result_rd !== 5'd5 || result_valid !== 1'b0) begin
      failures++; $display("FAIL mult_result_hold: result=%0d rd=%0d valid=%b expected 42 5 0",
                           result, result_rd, result_valid); end
  endtask

  task automatic test_flush();
    drive_op(1'b1, 1'b0, 32'd1, 32'd2, 5'd9, 4, 5, 1'b0, 32'd77, 3, 8);
    checks++; if (o_nrv !== 0 || o_nev !== 0) begin
      failures++; $display("FAIL flush_no_result: result_valid=%0d exc_valid=%0d expected 0 0", o_nrv, o_nev); end
    checks++; if (o_nstall !== 4 || o_last_stall !== 3) begin
      failures++; $display("FAIL flush_stall: cycles=%0d last=%0d expected 4 3", o_nstall, o_last_stall); end
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_idle: busy=%b expected 0", busy); end
    checks++; if (result !== 32'd42 || result_rd !== 5'd5) begin
      failures++; $display("FAIL flush_result_kept: result=%0d rd=%0d expected 42 5", result, result_rd); end
  endtask

  task automatic test_exceptions();
    drive_op(1'b0, 1'b1, 32'd10, 32'd0, 5'd3, 4, 2, 1'b1, 32'hDEAD_BEEF, -1, 6);
    checks++; if (o_ncd !== 1 || o_cd_cyc !== 1 || o_ncm !== 0) begin
      failures++; $display("FAIL div_ctrl_pulse: div=%0d cycle=%0d mult=%0d expected 1 1 0", o_ncd, o_cd_cyc, o_ncm); end
    checks++; if (o_nrv !== 1 || o_rv_cyc !== 3 || o_nstall !== 3) begin
      failures++; $display("FAIL div_timing: beats=%0d cycle=%0d stall=%0d expected 1 3 3", o_nrv, o_rv_cyc, o_nstall); end
    checks++; if (o_res !== 32'd0 || o_rd !== 5'd3 || o_exc !== 3'd5 || o_nev !== 1) begin
      failures++; $display("FAIL div_error: result=%h rd=%0d code=%0d exc_valid=%0d expected 0 3 5 1",
                           o_res, o_rd, o_exc, o_nev); end
    drive_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd4, 3, 1, 1'b1, 32'h1234_5678, -1, 5);
    checks++; if (o_nrv !== 1 || o_rv_cyc !== 2 || o_nstall !== 2) begin
      failures++; $display("FAIL mult_err_timing: beats=%0d cycle=%0d stall=%0d expected 1 2 2", o_nrv, o_rv_cyc, o_nstall); end
    checks++; if (o_res !== 32'd0 || o_rd !== 5'd4 || o_exc !== 3'd4 || o_nev !== 1) begin
      failures++; $display("FAIL mult_error: result=%h rd=%0d code=%0d exc_valid=%0d expected 0 4 4 1",
                           o_res, o_rd, o_exc, o_nev); end
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 1'b0, 32'd5, 32'd5, 5'd6, 42, -1, 1'b0, 32'd0, -1, 44);
    checks++; if (o_nrv !== 1 || o_rv_cyc !== 41) begin
      failures++; $display("FAIL timeout_beat: count=%0d cycle=%0d expected 1 41", o_nrv, o_rv_cyc); end
    checks++; if (o_exc !== 3'd6 || o_nev !== 1 || o_res !== 32'd0 || o_rd !== 5'd6) begin
      failures++; $display("FAIL timeout_code: code=%0d exc_valid=%0d result=%h rd=%0d expected 6 1 0 6",
                           o_exc, o_nev, o_res, o_rd); end
    checks++; if (o_nstall !== 41 || o_last_stall !== 40) begin
      failures++; $display("FAIL timeout_stall: cycles=%0d last=%0d expected 41 40", o_nstall, o_last_stall); end
  endtask

  task automatic test_back_to_back();
    int          nrv, nstall, ncm, ncd, cd_cyc, nev;
    int          rv_cyc[2];
    logic [31:0] rv_res[2];
    logic [4:0]  rv_rd[2];
    logic        stall_done;
    nrv = 0; nstall = 0; ncm = 0; ncd = 0; cd_cyc = -1; nev = 0; stall_done = 1'bx;
    rv_cyc[0] = -1; rv_cyc[1] = -1;
    rv_res[0] = 32'hx; rv_res[1] = 32'hx; rv_rd[0] = 5'hx; rv_rd[1] = 5'hx;
    for (int k = 0; k < 10; k++) begin
      req_mult    = (k <= 3);
      req_div     = (k >= 4) && (k <= 7);
      op_a        = (k <= 3) ? 32'd3 : 32'd100;
      op_b        = (k <= 3) ? 32'd5 : 32'd7;
      req_rd      = (k <= 3) ? 5'd1 : 5'd2;
      unit_ready  = (k == 2) || (k == 6);
      unit_result = (k == 2) ? 32'd15 : ((k == 6) ? 32'd14 : 32'h5A5A_5A5A);
      #1;
      if (stall) nstall++;
      if (k == 3) stall_done = stall;
      if (ctrl_mult) ncm++;
      if (ctrl_div) begin ncd++; cd_cyc = k; end
      if (exc_valid) nev++;
      if (result_valid) begin
        if (nrv < 2) begin rv_cyc[nrv] = k; rv_res[nrv] = result; rv_rd[nrv] = result_rd; end
        nrv++;
      end
      step();
    end
    idle_inputs();
    checks++; if (nrv !== 2) begin
      failures++; $display("FAIL b2b_beats: count=%0d expected 2", nrv); end
    checks++; if (rv_cyc[0] !== 3 || rv_res[0] !== 32'd15 || rv_rd[0] !== 5'd1) begin
      failures++; $display("FAIL b2b_first: cycle=%0d result=%0d rd=%0d expected 3 15 1", rv_cyc[0], rv_res[0], rv_rd[0]); end
    checks++; if (rv_cyc[1] !== 7 || rv_res[1] !== 32'd14 || rv_rd[1] !== 5'd2) begin
      failures++; $display("FAIL b2b_second: cycle=%0d result=%0d rd=%0d expected 7 14 2", rv_cyc[1], rv_res[1], rv_rd[1]); end
    checks++; if (ncm !== 1) begin
      failures++; $display("FAIL b2b_no_reissue: mult_pulses=%0d expected 1", ncm); end
    checks++; if (ncd !== 1 || cd_cyc !== 5) begin
      failures++; $display("FAIL b2b_div_issue: pulses=%0d cycle=%0d expected 1 5", ncd, cd_cyc); end
    checks++; if (nstall !== 6 || stall_done !== 1'b0 || nev !== 0) begin
      failures++; $display("FAIL b2b_stall: cycles=%0d stall_in_done=%b exc_valid=%0d expected 6 0 0",
                           nstall, stall_done, nev); end
  endtask

  task automatic test_reset_mid_op();
    logic [109:0] v;
    req_mult = 1'b1; req_div = 1'b1; op_a = 32'd11; op_b = 32'd22; req_rd = 5'd7;
    step();
    checks++; if (ctrl_mult !== 1'b1 || ctrl_div !== 1'b0 || unit_a !== 32'd11 || unit_b !== 32'd22) begin
      failures++; $display("FAIL both_req_mult_wins: mult=%b div=%b a=%0d b=%0d expected 1 0 11 22",
                           ctrl_mult, ctrl_div, unit_a, unit_b); end
    step();
    reset = 1'b0;
    step();
    req_mult = 1'b0; req_div = 1'b0;
    #1;
    v = {ctrl_mult, ctrl_div, unit_a, unit_b, stall, busy, result_valid, result, result_rd,
         exc_valid, exc_code};
    checks++; if (v !== 110'd0) begin
      failures++; $display("FAIL reset_mid_op_outputs: got %h expected 0", v); end
    step();
    reset = 1'b1; unit_ready = 1'b1; unit_result = 32'd99;
    #1;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_ready_ignored: busy=%b valid=%b stall=%b expected 0 0 0",
                           busy, result_valid, stall); end
    step();
    unit_ready = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0 || exc_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_no_late_beat: valid=%b exc=%b result=%0d busy=%b expected 0 0 0 0",
                           result_valid, exc_valid, result, busy); end
    step();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_mult();
    test_flush();
    test_exceptions();
    test_timeout();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
